// File: rtl/amba_axi_pkg.sv
// Shared AXI4 widths, encodings and channel bundles.
package amba_axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_mem_pkg.sv
// Types local to the AXI memory responder.
package axi_mem_pkg;
  import amba_axi_pkg::*;

  localparam int AXI_BPW = AXI_DATA_W / 8;
  localparam int LOG_BPW = $clog2(AXI_BPW);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_WAIT,
    ST_RD_DATA
  } axi_mem_st_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [7:0]            beat;
  } s_axi_mem_req_t;

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Next-beat address, word index, range and burst-legality decode.
module axi_mem_addr_gen
  import amba_axi_pkg::*, axi_mem_pkg::*;
#(
  parameter int                    MEM_WORDS = 1024,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  localparam int                   IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [AXI_ADDR_W-1:0] next_addr,
  output logic [IDX_W-1:0]      word_idx,
  output logic                  in_range,
  output logic                  xfer_err
);

  logic [AXI_ADDR_W-1:0] offset;
  logic [AXI_ADDR_W-1:0] step;

  // Base is aligned to the array size, so any bits above the index mean out of range.
  always_comb begin
    offset    = addr - BASE_ADDR;
    in_range  = (offset >> (LOG_BPW + IDX_W)) == '0;
    word_idx  = offset[LOG_BPW +: IDX_W];
    step      = AXI_ADDR_W'(1) << size;
    xfer_err  = (size > 3'(LOG_BPW)) ||
                ((burst != AXI_BURST_FIXED) && (burst != AXI_BURST_INCR));
    next_addr = (burst == AXI_BURST_INCR) ? addr + step : addr;
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 word-addressed memory responder, one transaction at a time.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | arbitrate AW vs AR, latch the winning request
// ST_WR_DATA | accept W beats, write strobed bytes
// ST_WR_RESP | present B until bready
// ST_RD_WAIT | burn RD_LATENCY cycles before the first R beat
// ST_RD_DATA | present R beats until the rlast handshake
module axi_mem_slave
  import amba_axi_pkg::*, axi_mem_pkg::*;
#(
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int                    RD_LATENCY = 0
) (
  input  logic        clk,
  input  logic        ares,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);

  localparam int         IDX_W    = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_INIT = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

  logic [AXI_DATA_W-1:0] mem [MEM_WORDS];

  axi_mem_st_t    state, state_d;
  s_axi_mem_req_t req, req_d;
  logic           err, err_d;
  logic           prio_wr, prio_wr_d;
  logic [3:0]     lat_cnt, lat_cnt_d;
  logic           sel_wr, sel_rd;
  logic           mem_we;

  logic [AXI_ADDR_W-1:0] next_addr;
  logic [IDX_W-1:0]      word_idx;
  logic                  in_range;
  logic                  xfer_err;
  logic                  beat_err;

  axi_mem_addr_gen #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .addr      (req.addr),
    .size      (req.size),
    .burst     (req.burst),
    .next_addr (next_addr),
    .word_idx  (word_idx),
    .in_range  (in_range),
    .xfer_err  (xfer_err)
  );

  assign beat_err = xfer_err | ~in_range;

  // State and request registers; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (ares) begin
      state   <= ST_IDLE;
      req     <= '0;
      err     <= 1'b0;
      prio_wr <= 1'b1;
      lat_cnt <= 4'd0;
    end else begin
      state   <= state_d;
      req     <= req_d;
      err     <= err_d;
      prio_wr <= prio_wr_d;
      lat_cnt <= lat_cnt_d;
    end
  end

  // Byte-lane writes; a beat in flight during reset is discarded.
  always_ff @(posedge clk) begin
    if (!ares && mem_we) begin
      for (int b = 0; b < AXI_STRB_W; b++) begin
        if (axi_mosi_i.wstrb[b]) mem[word_idx][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
      end
    end
  end

  // Next-state, request update and channel outputs.
  always_comb begin
    state_d    = state;
    req_d      = req;
    err_d      = err;
    prio_wr_d  = prio_wr;
    lat_cnt_d  = lat_cnt;
    sel_wr     = 1'b0;
    sel_rd     = 1'b0;
    mem_we     = 1'b0;
    axi_miso_o = '0;

    case (state)
      ST_IDLE: begin
        // On contention the flag picks the winner and then hands priority to the other side.
        sel_wr = axi_mosi_i.awvalid && (!axi_mosi_i.arvalid || prio_wr);
        sel_rd = axi_mosi_i.arvalid && !sel_wr;
        axi_miso_o.awready = sel_wr;
        axi_miso_o.arready = sel_rd;
        if (axi_mosi_i.awvalid && axi_mosi_i.arvalid) prio_wr_d = !prio_wr;
        if (sel_wr) begin
          req_d.id    = axi_mosi_i.awid;
          req_d.addr  = axi_mosi_i.awaddr;
          req_d.len   = axi_mosi_i.awlen;
          req_d.size  = axi_mosi_i.awsize;
          req_d.burst = axi_mosi_i.awburst;
          req_d.beat  = 8'd0;
          err_d       = 1'b0;
          state_d     = ST_WR_DATA;
        end else if (sel_rd) begin
          req_d.id    = axi_mosi_i.arid;
          req_d.addr  = axi_mosi_i.araddr;
          req_d.len   = axi_mosi_i.arlen;
          req_d.size  = axi_mosi_i.arsize;
          req_d.burst = axi_mosi_i.arburst;
          req_d.beat  = 8'd0;
          lat_cnt_d   = LAT_INIT;
          state_d     = (RD_LATENCY > 0) ? ST_RD_WAIT : ST_RD_DATA;
        end
      end
      ST_WR_DATA: begin
        axi_miso_o.wready = 1'b1;
        if (axi_mosi_i.wvalid) begin
          mem_we     = !beat_err;
          req_d.addr = next_addr;
          req_d.beat = req.beat + 8'd1;
          if (beat_err) err_d = 1'b1;
          // wlast ends the burst even when early; a missing wlast is covered by the beat count.
          if (axi_mosi_i.wlast && (req.beat != req.len)) err_d = 1'b1;
          if (axi_mosi_i.wlast || (req.beat == req.len)) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        axi_miso_o.bvalid = 1'b1;
        axi_miso_o.bid    = req.id;
        axi_miso_o.bresp  = err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (axi_mosi_i.bready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt == 4'd0) state_d = ST_RD_DATA;
        else                 lat_cnt_d = lat_cnt - 4'd1;
      end
      ST_RD_DATA: begin
        axi_miso_o.rvalid = 1'b1;
        axi_miso_o.rid    = req.id;
        axi_miso_o.rdata  = beat_err ? '0 : mem[word_idx];
        axi_miso_o.rresp  = beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        axi_miso_o.rlast  = (req.beat == req.len);
        if (axi_mosi_i.rready) begin
          req_d.addr = next_addr;
          req_d.beat = req.beat + 8'd1;
          if (req.beat == req.len) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
